alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU (rs, rt, op -> rd) between two requesters.
//  Round-robin arbitration; valid/ready handshakes on both request ports and on the result port.
//  Operands are registered and held stable for EXEC_CYCLES while the ALU settles.
//  The result is returned with the requester id.
//  Sits between the core's execute stages and the shared ALU instance.
// PARAMETERS
//  EXEC_CYCLES  1   cycles operands are held before rd is sampled (1..15; >1 for slow mul/div paths)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  req0_valid in   1   requester 0 has an operation
//  req0_ready out  1   requester 0 accepted this cycle (when valid)
//  req0_rs    in   32  requester 0 first operand
//  req0_rt    in   32  requester 0 second operand
//  req0_op    in   4   requester 0 op: 1000 add, 0100 sub, 0010 mul, 0001 div, other = add
//  req1_*     -    -   same set for requester 1
//  alu_rs     out  32  operand to shared ALU (registered)
//  alu_rt     out  32  operand to shared ALU (registered)
//  alu_op     out  4   op to shared ALU (registered)
//  alu_rd     in   32  ALU result (combinational from alu_rs/alu_rt/alu_op)
//  rsp_valid  out  1   result available
//  rsp_ready  in   1   consumer takes result
//  rsp_rd     out  32  registered result
//  rsp_id     out  1   requester that issued the op
//  rsp_err    out  1   divide by zero (op 0001 with rt == 0)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; cnt 0; last_gnt = 1, so requester 0 wins first.
//  FSM IDLE -> EXEC -> RESP -> IDLE. No overlap: one op in flight.
//  Grant (comb., IDLE only):
//    - only one valid -> grant it
//    - both valid -> grant ~last_gnt
//    - none valid -> no grant
//  reqN_ready = (state==IDLE) && reqN_valid && gnt==N; never high for both ports.
//  Accept edge (valid&&ready):
//    - latch rs/rt/op into alu_* and id
//    - last_gnt <= N; cnt <= EXEC_CYCLES-1
//    - state <= EXEC
//  EXEC:
//    - cnt != 0 -> cnt--
//    - cnt == 0 -> rsp_rd <= alu_rd; rsp_err <= (op==0001 && rt==0); state <= RESP
//  Div-by-zero: rsp_rd = 32'hFFFFFFFF (ALU output ignored); rsp_err = 1.
//  RESP:
//    - rsp_valid = 1; rsp_rd/rsp_id/rsp_err held stable until rsp_valid && rsp_ready
//    - handshake -> state <= IDLE
//  Latency: accept at edge k -> rsp_valid high from edge k+EXEC_CYCLES.
//    Next accept is no earlier than edge k+EXEC_CYCLES+2.
//  alu_* hold their values after EXEC until the next accept.
//  Unknown op codes pass through to alu_op unchanged; the ALU treats them as add.
//  Arithmetic is 32-bit unsigned, wrap-around; mul keeps the low 32 bits.
//  rst in any state (mid EXEC, mid RESP) aborts the in-flight op with no response.
//    Returns to reset values on the next edge.
//  A requester that drops valid before ready is never granted; no request is latched.
// TESTING
//  1. p0 rs=12 rt=13 op=1000, E=1 -> req0_ready in cycle 0; rsp_valid at +1; rd=25, id=0, err=0.
//  2. Reset, then p0 (20-10, 0100) and p1 (5*6, 0010) both valid, rsp_ready=1 ->
//     p0 served first (rd=10, id=0), then p1 (rd=30, id=1).
//  3. Both held valid for 4 ops -> grants alternate 0,1,0,1 (check last_gnt fairness).
//  4. E=3, p1 25/5 op 0001 -> rsp_valid exactly 3 cycles after accept; rd=5.
//     alu_rs/rt/op are stable throughout.
//  5. p0 rt=0 op=0001 -> rd=FFFFFFFF, err=1.
//     Hold rsp_ready=0 for 5 cycles -> rsp_* stable and both req*_ready = 0.
//  6. rst pulsed mid EXEC -> no rsp_valid; all outputs 0.
//     Next p1 op 0111 (7+3) is accepted and returns rd=10.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rs,
    input  logic [31:0] req0_rt,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rs,
    input  logic [31:0] req1_rt,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rt,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        rsp_id,
    output logic        rsp_err
);

    localparam logic [3:0] OP_DIV   = 4'b0001;
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic        id_q, id_d;
    logic [31:0] alu_rs_q, alu_rs_d;
    logic [31:0] alu_rt_q, alu_rt_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_err_q, rsp_err_d;

    logic gnt_any;
    logic gnt_id;
    logic div_zero;

    // Grant only exists in IDLE; on contention the port not served last wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = ~last_gnt_q;
            end else if (req0_valid) begin
                gnt_any = 1'b1;
            end else if (req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any && gnt_id;
    assign div_zero   = (alu_op_q == OP_DIV) && (alu_rt_q == 32'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_gnt_d  = last_gnt_q;
        id_d        = id_q;
        alu_rs_d    = alu_rs_q;
        alu_rt_d    = alu_rt_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    alu_rs_d   = gnt_id ? req1_rs : req0_rs;
                    alu_rt_d   = gnt_id ? req1_rt : req0_rt;
                    alu_op_d   = gnt_id ? req1_op : req0_op;
                    id_d       = gnt_id;
                    last_gnt_d = gnt_id;
                    cnt_d      = CNT_INIT;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_rd_d    = div_zero ? 32'hFFFF_FFFF : alu_rd;
                    rsp_err_d   = div_zero;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_gnt_q  <= 1'b1;
            id_q        <= 1'b0;
            alu_rs_q    <= 32'd0;
            alu_rt_q    <= 32'd0;
            alu_op_q    <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 32'd0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            id_q        <= id_d;
            alu_rs_q    <= alu_rs_d;
            alu_rt_q    <= alu_rt_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_rs    = alu_rs_q;
    assign alu_rt    = alu_rt_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (EXEC_CYCLES 1 and 3 instances)
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid, rsp_ready;
    logic [31:0] r0_rs, r0_rt, r1_rs, r1_rt;
    logic [3:0]  r0_op, r1_op;

    logic        a_r0_ready, a_r1_ready, a_rsp_valid, a_rsp_id, a_rsp_err;
    logic [31:0] a_alu_rs, a_alu_rt, a_alu_rd, a_rsp_rd;
    logic [3:0]  a_alu_op;
    logic        b_r0_ready, b_r1_ready, b_rsp_valid, b_rsp_id, b_rsp_err;
    logic [31:0] b_alu_rs, b_alu_rt, b_alu_rd, b_rsp_rd;
    logic [3:0]  b_alu_op;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [3:0] op);
        case (op)
            4'b0100: return rs - rt;
            4'b0010: return rs * rt;
            4'b0001: return (rt == 32'd0) ? 32'd0 : rs / rt;
            default: return rs + rt;
        endcase
    endfunction

    assign a_alu_rd = alu_f(a_alu_rs, a_alu_rt, a_alu_op);
    assign b_alu_rd = alu_f(b_alu_rs, b_alu_rt, b_alu_op);

    alu_arbiter #(.EXEC_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_ready(a_r0_ready), .req0_rs(r0_rs), .req0_rt(r0_rt), .req0_op(r0_op),
        .req1_valid(r1_valid), .req1_ready(a_r1_ready), .req1_rs(r1_rs), .req1_rt(r1_rt), .req1_op(r1_op),
        .alu_rs(a_alu_rs), .alu_rt(a_alu_rt), .alu_op(a_alu_op), .alu_rd(a_alu_rd),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(a_rsp_rd), .rsp_id(a_rsp_id),
        .rsp_err(a_rsp_err)
    );

    alu_arbiter #(.EXEC_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_ready(b_r0_ready), .req0_rs(r0_rs), .req0_rt(r0_rt), .req0_op(r0_op),
        .req1_valid(r1_valid), .req1_ready(b_r1_ready), .req1_rs(r1_rs), .req1_rt(r1_rt), .req1_op(r1_op),
        .alu_rs(b_alu_rs), .alu_rt(b_alu_rt), .alu_op(b_alu_op), .alu_rd(b_alu_rd),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(b_rsp_rd), .rsp_id(b_rsp_id),
        .rsp_err(b_rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        r0_rs = '0; r0_rt = '0; r0_op = '0;
        r1_rs = '0; r1_rt = '0; r1_op = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err} !== 35'd0) begin
            $display("FAIL reset_rsp: got valid=%b rd=%h id=%b err=%b, want all 0",
                     a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err);
            n_err++;
        end
        n_vec++;
        if ({a_alu_rs, a_alu_rt, a_alu_op, a_r0_ready, a_r1_ready} !== 70'd0) begin
            $display("FAIL reset_alu: got rs=%h rt=%h op=%h rdy=%b%b, want all 0",
                     a_alu_rs, a_alu_rt, a_alu_op, a_r0_ready, a_r1_ready);
            n_err++;
        end
    endtask

    task automatic test_single();
        r0_valid = 1'b1; r0_rs = 32'd12; r0_rt = 32'd13; r0_op = 4'b1000; rsp_ready = 1'b1;
        #1;
        n_vec++;
        if ({a_r0_ready, a_r1_ready} !== 2'b10) begin
            $display("FAIL single_ready: got %b%b, want 10", a_r0_ready, a_r1_ready);
            n_err++;
        end
        tick();
        r0_valid = 1'b0;
        n_vec++;
        if (a_rsp_valid !== 1'b0 || a_alu_rs !== 32'd12) begin
            $display("FAIL single_exec: got valid=%b alu_rs=%0d, want 0/12", a_rsp_valid, a_alu_rs);
            n_err++;
        end
        tick();
        n_vec++;
        if ({a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err} !== {1'b1, 32'd25, 1'b0, 1'b0}) begin
            $display("FAIL single_rsp: got valid=%b rd=%0d id=%b err=%b, want 1/25/0/0",
                     a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err);
            n_err++;
        end
        tick();
        n_vec++;
        if (a_rsp_valid !== 1'b0) begin
            $display("FAIL single_done: got valid=%b, want 0", a_rsp_valid);
            n_err++;
        end
    endtask

    task automatic test_both_valid();
        do_reset();
        r0_valid = 1'b1; r0_rs = 32'd20; r0_rt = 32'd10; r0_op = 4'b0100;
        r1_valid = 1'b1; r1_rs = 32'd5;  r1_rt = 32'd6;  r1_op = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        n_vec++;
        if ({a_r0_ready, a_r1_ready} !== 2'b10) begin
            $display("FAIL both_first_gnt: got %b%b, want 10", a_r0_ready, a_r1_ready);
            n_err++;
        end
        tick();
        r0_valid = 1'b0;
        tick();
        n_vec++;
        if ({a_rsp_valid, a_rsp_rd, a_rsp_id} !== {1'b1, 32'd10, 1'b0}) begin
            $display("FAIL both_rsp0: got valid=%b rd=%0d id=%b, want 1/10/0",
                     a_rsp_valid, a_rsp_rd, a_rsp_id);
            n_err++;
        end
        tick();
        n_vec++;
        if ({a_r0_ready, a_r1_ready} !== 2'b01) begin
            $display("FAIL both_second_gnt: got %b%b, want 01", a_r0_ready, a_r1_ready);
            n_err++;
        end
        tick();
        r1_valid = 1'b0;
        tick();
        n_vec++;
        if ({a_rsp_valid, a_rsp_rd, a_rsp_id} !== {1'b1, 32'd30, 1'b1}) begin
            $display("FAIL both_rsp1: got valid=%b rd=%0d id=%b, want 1/30/1",
                     a_rsp_valid, a_rsp_rd, a_rsp_id);
            n_err++;
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] ids;
        int         got;
        int         cyc;
        ids = '0;
        got = 0;
        cyc = 0;
        r0_valid = 1'b1; r0_rs = 32'd1; r0_rt = 32'd1; r0_op = 4'b1000;
        r1_valid = 1'b1; r1_rs = 32'd7; r1_rt = 32'd2; r1_op = 4'b0100;
        rsp_ready = 1'b1;
        while (got < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (a_rsp_valid === 1'b1) begin
                ids[got] = a_rsp_id;
                n_vec++;
                if (a_rsp_rd !== (a_rsp_id ? 32'd5 : 32'd2)) begin
                    $display("FAIL fair_rd%0d: got rd=%0d for id=%b, want %0d",
                             got, a_rsp_rd, a_rsp_id, a_rsp_id ? 5 : 2);
                    n_err++;
                end
                got++;
            end
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        n_vec++;
        if (got != 4 || ids !== 4'b1010) begin
            $display("FAIL fair_order: got %0d rsps ids(3..0)=%b, want 4 rsps ids=1010", got, ids);
            n_err++;
        end
        tick();
        tick();
    endtask

    task automatic test_exec3();
        do_reset();
        r1_valid = 1'b1; r1_rs = 32'd25; r1_rt = 32'd5; r1_op = 4'b0001;
        #1;
        n_vec++;
        if (b_r1_ready !== 1'b1) begin
            $display("FAIL e3_ready: got %b, want 1", b_r1_ready);
            n_err++;
        end
        tick();
        r1_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++;
            if (b_rsp_valid !== (i == 3)) begin
                $display("FAIL e3_valid_cyc%0d: got %b, want %b", i, b_rsp_valid, i == 3);
                n_err++;
            end
            n_vec++;
            if ({b_alu_rs, b_alu_rt, b_alu_op} !== {32'd25, 32'd5, 4'b0001}) begin
                $display("FAIL e3_alu_cyc%0d: got %0d/%0d/%b, want 25/5/0001",
                         i, b_alu_rs, b_alu_rt, b_alu_op);
                n_err++;
            end
        end
        n_vec++;
        if ({b_rsp_rd, b_rsp_id, b_rsp_err} !== {32'd5, 1'b1, 1'b0}) begin
            $display("FAIL e3_rsp: got rd=%0d id=%b err=%b, want 5/1/0", b_rsp_rd, b_rsp_id, b_rsp_err);
            n_err++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_div_zero_stall();
        r0_valid = 1'b1; r0_rs = 32'd99; r0_rt = 32'd0; r0_op = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        n_vec++;
        if (a_r0_ready !== 1'b1) begin
            $display("FAIL dz_ready: got %b, want 1", a_r0_ready);
            n_err++;
        end
        tick();
        r1_valid = 1'b1; r1_rs = 32'd1; r1_rt = 32'd1; r1_op = 4'b1000;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err} !== {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1}) begin
                $display("FAIL dz_hold%0d: got valid=%b rd=%h id=%b err=%b, want 1/FFFFFFFF/0/1",
                         i, a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err);
                n_err++;
            end
            n_vec++;
            if ({a_r0_ready, a_r1_ready} !== 2'b00) begin
                $display("FAIL dz_ready_hold%0d: got %b%b, want 00", i, a_r0_ready, a_r1_ready);
                n_err++;
            end
            tick();
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        n_vec++;
        if (a_rsp_valid !== 1'b0) begin
            $display("FAIL dz_release: got valid=%b, want 0", a_rsp_valid);
            n_err++;
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        r0_valid = 1'b1; r0_rs = 32'd3; r0_rt = 32'd4; r0_op = 4'b1000;
        tick();
        r0_valid = 1'b0;
        rsp_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err, a_alu_rs, a_alu_rt, a_alu_op} !== 103'd0
                || b_rsp_valid !== 1'b0) begin
                $display("FAIL rstmid_cyc%0d: got a_valid=%b rd=%h alu_rs=%h b_valid=%b, want all 0",
                         i, a_rsp_valid, a_rsp_rd, a_alu_rs, b_rsp_valid);
                n_err++;
            end
            tick();
        end
        r1_valid = 1'b1; r1_rs = 32'd7; r1_rt = 32'd3; r1_op = 4'b0111;
        #1;
        n_vec++;
        if ({a_r0_ready, a_r1_ready} !== 2'b01) begin
            $display("FAIL rstmid_gnt: got %b%b, want 01", a_r0_ready, a_r1_ready);
            n_err++;
        end
        tick();
        r1_valid = 1'b0;
        tick();
        n_vec++;
        if ({a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err, a_alu_op} !== {1'b1, 32'd10, 1'b1, 1'b0, 4'b0111}) begin
            $display("FAIL rstmid_rsp: got valid=%b rd=%0d id=%b err=%b op=%b, want 1/10/1/0/0111",
                     a_rsp_valid, a_rsp_rd, a_rsp_id, a_rsp_err, a_alu_op);
            n_err++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_both_valid();
        test_fairness();
        test_exec3();
        test_div_zero_stall();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
